// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the RAM loader: FSM state encoding and byte-lane helpers.
package ram_loader_pkg;

    localparam int unsigned BYTE_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        VERIFY_ADDR,
        VERIFY_CHECK,
        DONE
    } state_e;

    // Lane counter width; a one-byte word still needs a 1-bit counter.
    function automatic int unsigned lane_width(input int unsigned bytes_per_word);
        return (bytes_per_word > 1) ? $clog2(bytes_per_word) : 1;
    endfunction

endpackage

// File: rtl/RamPort.sv
// Single-port RAM bus; the CPU side drives the request, memory returns registered read data.
interface RamPort #(
    parameter int unsigned AddressWidth = 8,
    parameter int unsigned DataWidth    = 16
);
    logic                    enable;
    logic                    write_enable;
    logic [AddressWidth-1:0] address;
    logic [DataWidth-1:0]    write_data;
    logic [DataWidth-1:0]    read_data;

    modport Cpu (
        output enable,
        output write_enable,
        output address,
        output write_data,
        input  read_data
    );

    modport Mem (
        input  enable,
        input  write_enable,
        input  address,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/ram_loader_byte_packer.sv
// Packs a little-endian byte stream into DataWidth words; flags the cycle that completes a word.
module ram_loader_byte_packer
    import ram_loader_pkg::*;
#(
    parameter int unsigned DataWidth = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_accept,
    input  logic [BYTE_WIDTH-1:0] i_byte,
    output logic [DataWidth-1:0]  o_word_c,
    output logic                  o_full_c
);

    localparam int unsigned BytesPerWord = DataWidth / BYTE_WIDTH;
    localparam int unsigned LaneWidth    = lane_width(BytesPerWord);

    logic [LaneWidth-1:0] lane_q;
    logic [LaneWidth-1:0] lane_d;
    logic [DataWidth-1:0] buffer_q;
    logic [DataWidth-1:0] buffer_d;

    // o_word_c already contains the byte being accepted so the word is usable on the completing edge.
    always_comb begin
        o_word_c = buffer_q;
        for (int unsigned i = 0; i < BytesPerWord; i++) begin
            if (lane_q == LaneWidth'(i)) begin
                o_word_c[i*BYTE_WIDTH +: BYTE_WIDTH] = i_byte;
            end
        end
        o_full_c = i_accept && (lane_q == LaneWidth'(BytesPerWord - 1));

        lane_d   = lane_q;
        buffer_d = buffer_q;
        if (i_clear) begin
            lane_d   = '0;
            buffer_d = '0;
        end else if (i_accept) begin
            buffer_d = o_full_c ? '0 : o_word_c;
            lane_d   = o_full_c ? '0 : lane_q + LaneWidth'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            lane_q   <= '0;
            buffer_q <= '0;
        end else begin
            lane_q   <= lane_d;
            buffer_q <= buffer_d;
        end
    end

endmodule

// File: rtl/ram_loader.sv
// Fills a memory region from a byte stream, reads it back, and reports a checksum and a verify error.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int unsigned AddressWidth = 8,
    parameter int unsigned DataWidth    = 16
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [AddressWidth-1:0] i_base_address,
    input  logic [AddressWidth:0]   i_word_count,
    input  logic                    i_byte_valid,
    input  logic [BYTE_WIDTH-1:0]   i_byte,
    output logic                    o_byte_ready,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error,
    output logic [DataWidth-1:0]    o_checksum,
    RamPort.Cpu                     ram
);

    localparam int unsigned CountWidth = AddressWidth + 1;

    state_e                  state_q;
    logic [AddressWidth-1:0] base_q;
    logic [CountWidth-1:0]   count_q;
    logic [CountWidth-1:0]   word_index_q;
    logic [DataWidth-1:0]    load_sum_q;
    logic [DataWidth-1:0]    verify_sum_q;
    logic                    byte_ready_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    error_q;
    logic [DataWidth-1:0]    checksum_q;
    logic                    ram_enable_q;
    logic                    ram_write_enable_q;
    logic [AddressWidth-1:0] ram_address_q;
    logic [DataWidth-1:0]    ram_write_data_q;

    logic                    accept_c;
    logic                    last_word_c;
    logic [CountWidth-1:0]   next_index_c;
    logic [AddressWidth-1:0] address_c;
    logic [AddressWidth-1:0] next_address_c;
    logic [DataWidth-1:0]    verify_total_c;
    logic                    packer_clear_c;
    logic [DataWidth-1:0]    packed_word_c;
    logic                    packed_full_c;

    assign accept_c       = (state_q == COLLECT) && i_byte_valid && byte_ready_q;
    assign next_index_c   = word_index_q + CountWidth'(1);
    assign last_word_c    = (next_index_c == count_q);
    assign address_c      = base_q + word_index_q[AddressWidth-1:0];
    assign next_address_c = base_q + next_index_c[AddressWidth-1:0];
    assign verify_total_c = verify_sum_q + ram.read_data;
    assign packer_clear_c = (state_q == IDLE);

    ram_loader_byte_packer #(
        .DataWidth (DataWidth)
    ) u_packer (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_clear  (packer_clear_c),
        .i_accept (accept_c),
        .i_byte   (i_byte),
        .o_word_c (packed_word_c),
        .o_full_c (packed_full_c)
    );

    // Outputs are loaded on the edge that enters a state, so they are valid for that whole state.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q            <= IDLE;
            base_q             <= '0;
            count_q            <= '0;
            word_index_q       <= '0;
            load_sum_q         <= '0;
            verify_sum_q       <= '0;
            byte_ready_q       <= 1'b0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            error_q            <= 1'b0;
            checksum_q         <= '0;
            ram_enable_q       <= 1'b0;
            ram_write_enable_q <= 1'b0;
            ram_address_q      <= '0;
            ram_write_data_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        base_q       <= i_base_address;
                        count_q      <= i_word_count;
                        word_index_q <= '0;
                        load_sum_q   <= '0;
                        verify_sum_q <= '0;
                        error_q      <= 1'b0;
                        checksum_q   <= '0;
                        if (i_word_count == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q      <= COLLECT;
                            busy_q       <= 1'b1;
                            byte_ready_q <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (packed_full_c) begin
                        state_q            <= WRITE;
                        byte_ready_q       <= 1'b0;
                        ram_enable_q       <= 1'b1;
                        ram_write_enable_q <= 1'b1;
                        ram_address_q      <= address_c;
                        ram_write_data_q   <= packed_word_c;
                    end
                end
                WRITE: begin
                    load_sum_q         <= load_sum_q + ram_write_data_q;
                    ram_write_enable_q <= 1'b0;
                    ram_write_data_q   <= '0;
                    if (last_word_c) begin
                        state_q       <= VERIFY_ADDR;
                        word_index_q  <= '0;
                        ram_enable_q  <= 1'b1;
                        ram_address_q <= base_q;
                    end else begin
                        state_q       <= COLLECT;
                        word_index_q  <= next_index_c;
                        byte_ready_q  <= 1'b1;
                        ram_enable_q  <= 1'b0;
                        ram_address_q <= '0;
                    end
                end
                VERIFY_ADDR: begin
                    state_q       <= VERIFY_CHECK;
                    ram_enable_q  <= 1'b0;
                    ram_address_q <= '0;
                end
                VERIFY_CHECK: begin
                    verify_sum_q <= verify_total_c;
                    if (last_word_c) begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        checksum_q <= load_sum_q;
                        error_q    <= (load_sum_q != verify_total_c);
                    end else begin
                        state_q       <= VERIFY_ADDR;
                        word_index_q  <= next_index_c;
                        ram_enable_q  <= 1'b1;
                        ram_address_q <= next_address_c;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_byte_ready     = byte_ready_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_error          = error_q;
    assign o_checksum       = checksum_q;
    assign ram.enable       = ram_enable_q;
    assign ram.write_enable = ram_write_enable_q;
    assign ram.address      = ram_address_q;
    assign ram.write_data   = ram_write_data_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader with an 8-bit address, 16-bit word behavioural RAM.
module tb_ram_loader;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_start;
    logic [7:0] i_base_address;
    logic [8:0] i_word_count;
    logic       i_byte_valid;
    logic [7:0] i_byte;
    logic       o_byte_ready;
    logic       o_busy;
    logic       o_done;
    logic       o_error;
    logic [15:0] o_checksum;

    int total = 0;
    int bad   = 0;

    logic        corrupt = 1'b0;
    logic [15:0] mem [256];
    int          en_cnt = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;

    RamPort #(.AddressWidth(8), .DataWidth(16)) ram_if ();

    ram_loader #(.AddressWidth(8), .DataWidth(16)) dut (
        .i_clock        (clk),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_base_address (i_base_address),
        .i_word_count   (i_word_count),
        .i_byte_valid   (i_byte_valid),
        .i_byte         (i_byte),
        .o_byte_ready   (o_byte_ready),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_error        (o_error),
        .o_checksum     (o_checksum),
        .ram            (ram_if)
    );

    always #5 clk = ~clk;

    // Behavioural RAM; 'corrupt' flips bit 0 of anything written to 0x11.
    always @(posedge clk) begin
        if (ram_if.enable && ram_if.write_enable) begin
            if (corrupt && ram_if.address == 8'h11) mem[ram_if.address] <= ram_if.write_data ^ 16'h0001;
            else mem[ram_if.address] <= ram_if.write_data;
        end
        if (ram_if.enable && !ram_if.write_enable) ram_if.read_data <= mem[ram_if.address];
        if (ram_if.enable) en_cnt <= en_cnt + 1;
        if (ram_if.enable && ram_if.write_enable) wr_cnt <= wr_cnt + 1;
        if (o_done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a load and streams bytes (valid every 'period' cycles); returns cycle of o_done (0 = timeout).
    task automatic run_load(input logic [7:0] base, input logic [8:0] cnt, input logic [31:0] bytes,
                            input int period, input int mid_k,
                            output int done_cyc, output int first_wr_idx, output logic err_at_done);
        int   idx;
        int   nbytes;
        logic acc;
        idx = 0;
        nbytes = int'(cnt) * 2;
        done_cyc = 0;
        first_wr_idx = -1;
        err_at_done = 1'b0;
        i_base_address = base;
        i_word_count = cnt;
        i_start = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (k == mid_k) begin
                i_start = 1'b1;
                i_base_address = 8'h40;
                i_word_count = 9'd1;
            end
            if (idx < nbytes && (k % period) == 0) begin
                i_byte_valid = 1'b1;
                i_byte = bytes[8*idx +: 8];
            end else begin
                i_byte_valid = 1'b0;
            end
            acc = i_byte_valid && o_byte_ready;
            tick();
            i_start = 1'b0;
            if (acc) idx++;
            if (ram_if.write_enable && first_wr_idx < 0) first_wr_idx = idx;
            if (o_done) begin
                done_cyc = k + 1;
                err_at_done = o_error;
                break;
            end
        end
        i_byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_start = 1'b0;
        i_base_address = '0;
        i_word_count = '0;
        i_byte_valid = 1'b0;
        i_byte = '0;
        repeat (3) tick();
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", o_done); end
        total++; if (o_error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", o_error); end
        total++; if (o_byte_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", o_byte_ready); end
        total++; if (o_checksum !== 16'h0) begin bad++; $display("FAIL reset_checksum: got %h want 0000", o_checksum); end
        total++; if ({ram_if.enable, ram_if.write_enable} !== 2'b00) begin
            bad++; $display("FAIL reset_ram_ctl: got %b want 00", {ram_if.enable, ram_if.write_enable}); end
        total++; if ({ram_if.address, ram_if.write_data} !== 24'h0) begin
            bad++; $display("FAIL reset_ram_bus: got %h want 000000", {ram_if.address, ram_if.write_data}); end
        i_reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int dc, fw, d0, w0;
        logic er;
        d0 = done_cnt; w0 = wr_cnt;
        run_load(8'h10, 9'd2, 32'h5678_1234, 1, -1, dc, fw, er);
        repeat (3) tick();
        total++; if (dc !== 11) begin bad++; $display("FAIL basic_latency: got %0d want 11", dc); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - d0); end
        total++; if (mem[8'h10] !== 16'h1234) begin bad++; $display("FAIL basic_mem10: got %h want 1234", mem[8'h10]); end
        total++; if (mem[8'h11] !== 16'h5678) begin bad++; $display("FAIL basic_mem11: got %h want 5678", mem[8'h11]); end
        total++; if (o_checksum !== 16'h68AC) begin bad++; $display("FAIL basic_checksum: got %h want 68ac", o_checksum); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL basic_error: got %b want 0", er); end
        total++; if (wr_cnt - w0 !== 2) begin bad++; $display("FAIL basic_writes: got %0d want 2", wr_cnt - w0); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", o_busy); end
    endtask

    task automatic test_wrap();
        int dc, fw, w0;
        logic er;
        w0 = wr_cnt;
        run_load(8'hFF, 9'd2, 32'hDDCC_BBAA, 1, -1, dc, fw, er);
        repeat (2) tick();
        total++; if (mem[8'hFF] !== 16'hBBAA) begin bad++; $display("FAIL wrap_memff: got %h want bbaa", mem[8'hFF]); end
        total++; if (mem[8'h00] !== 16'hDDCC) begin bad++; $display("FAIL wrap_mem00: got %h want ddcc", mem[8'h00]); end
        total++; if (wr_cnt - w0 !== 2) begin bad++; $display("FAIL wrap_writes: got %0d want 2", wr_cnt - w0); end
        total++; if (o_checksum !== 16'h9976) begin bad++; $display("FAIL wrap_checksum: got %h want 9976", o_checksum); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL wrap_error: got %b want 0", er); end
    endtask

    task automatic test_zero_count();
        int dc, fw, e0;
        logic er;
        e0 = en_cnt;
        run_load(8'h20, 9'd0, 32'h0, 1, -1, dc, fw, er);
        repeat (3) tick();
        total++; if (dc !== 1) begin bad++; $display("FAIL zero_latency: got %0d want 1", dc); end
        total++; if (en_cnt - e0 !== 0) begin bad++; $display("FAIL zero_enable: got %0d want 0", en_cnt - e0); end
        total++; if (o_checksum !== 16'h0) begin bad++; $display("FAIL zero_checksum: got %h want 0000", o_checksum); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL zero_error: got %b want 0", er); end
    endtask

    task automatic test_backpressure();
        int dc, fw, w0;
        logic er;
        w0 = wr_cnt;
        run_load(8'h10, 9'd2, 32'h5678_1234, 3, -1, dc, fw, er);
        repeat (2) tick();
        total++; if (fw !== 2) begin bad++; $display("FAIL bp_first_write_bytes: got %0d want 2", fw); end
        total++; if (dc <= 11) begin bad++; $display("FAIL bp_latency: got %0d want >11", dc); end
        total++; if (mem[8'h10] !== 16'h1234) begin bad++; $display("FAIL bp_mem10: got %h want 1234", mem[8'h10]); end
        total++; if (mem[8'h11] !== 16'h5678) begin bad++; $display("FAIL bp_mem11: got %h want 5678", mem[8'h11]); end
        total++; if (wr_cnt - w0 !== 2) begin bad++; $display("FAIL bp_writes: got %0d want 2", wr_cnt - w0); end
        total++; if (o_checksum !== 16'h68AC) begin bad++; $display("FAIL bp_checksum: got %h want 68ac", o_checksum); end
    endtask

    task automatic test_verify_fail();
        int dc, fw;
        logic er;
        corrupt = 1'b1;
        run_load(8'h10, 9'd2, 32'h5678_1234, 1, -1, dc, fw, er);
        corrupt = 1'b0;
        total++; if (er !== 1'b1) begin bad++; $display("FAIL vf_error_at_done: got %b want 1", er); end
        total++; if (mem[8'h11] !== 16'h5679) begin bad++; $display("FAIL vf_mem11: got %h want 5679", mem[8'h11]); end
        total++; if (o_checksum !== 16'h68AC) begin bad++; $display("FAIL vf_checksum: got %h want 68ac", o_checksum); end
        repeat (5) tick();
        total++; if (o_error !== 1'b1) begin bad++; $display("FAIL vf_error_sticky: got %b want 1", o_error); end
        run_load(8'h10, 9'd2, 32'h5678_1234, 1, -1, dc, fw, er);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL vf_rerun_error: got %b want 0", er); end
        total++; if (dc !== 11) begin bad++; $display("FAIL vf_rerun_latency: got %0d want 11", dc); end
        tick();
    endtask

    task automatic test_busy_start();
        int dc, fw, w0;
        logic er;
        w0 = wr_cnt;
        run_load(8'h10, 9'd2, 32'h5678_1234, 1, 4, dc, fw, er);
        repeat (2) tick();
        total++; if (dc !== 11) begin bad++; $display("FAIL busy_start_latency: got %0d want 11", dc); end
        total++; if (wr_cnt - w0 !== 2) begin bad++; $display("FAIL busy_start_writes: got %0d want 2", wr_cnt - w0); end
        total++; if (mem[8'h11] !== 16'h5678) begin bad++; $display("FAIL busy_start_mem11: got %h want 5678", mem[8'h11]); end
        total++; if (o_checksum !== 16'h68AC) begin bad++; $display("FAIL busy_start_checksum: got %h want 68ac", o_checksum); end
    endtask

    task automatic test_reset_mid();
        int dc, fw, d0;
        logic er;
        d0 = done_cnt;
        i_base_address = 8'h10;
        i_word_count = 9'd2;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_byte_valid = 1'b1;
        i_byte = 8'hEF;
        tick();
        i_byte = 8'hBE;
        tick();
        i_byte_valid = 1'b0;
        total++; if (ram_if.write_enable !== 1'b1) begin bad++; $display("FAIL rm_write_phase: got %b want 1", ram_if.write_enable); end
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rm_busy: got %b want 0", o_busy); end
        total++; if (ram_if.enable !== 1'b0) begin bad++; $display("FAIL rm_enable: got %b want 0", ram_if.enable); end
        total++; if (o_byte_ready !== 1'b0) begin bad++; $display("FAIL rm_ready: got %b want 0", o_byte_ready); end
        total++; if (mem[8'h10] !== 16'hBEEF) begin bad++; $display("FAIL rm_mem10: got %h want beef", mem[8'h10]); end
        repeat (12) tick();
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL rm_no_done: got %0d want 0", done_cnt - d0); end
        run_load(8'h10, 9'd2, 32'h5678_1234, 1, -1, dc, fw, er);
        tick();
        total++; if (dc !== 11) begin bad++; $display("FAIL rm_fresh_latency: got %0d want 11", dc); end
        total++; if (mem[8'h10] !== 16'h1234) begin bad++; $display("FAIL rm_fresh_mem10: got %h want 1234", mem[8'h10]); end
        total++; if (o_checksum !== 16'h68AC) begin bad++; $display("FAIL rm_fresh_checksum: got %h want 68ac", o_checksum); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero_count();
        test_backpressure();
        test_verify_fail();
        test_busy_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
